// File: rtl/pulse_skew_calib.sv
// Deskew calibration engine: timestamps the first rising edge of a training
// pulse on every lane and turns the skews into per-lane delay selects.
module pulse_skew_calib #(
  parameter int NUM_LANES = 4,
  parameter int MAX_DLY   = 3,
  parameter int TIMEOUT   = 15,
  localparam int SEL_W    = $clog2(MAX_DLY + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_LANES-1:0]       lane_pulse,
  output logic [NUM_LANES*SEL_W-1:0] sel_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_COMPUTE = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_LANES-1:0]            prev_q;
  logic [NUM_LANES-1:0]            flag_q, flag_d;
  logic [NUM_LANES-1:0][SEL_W-1:0] off_q, off_d;
  logic [SEL_W-1:0]                skew_q, skew_d;
  logic [TMO_W-1:0]                tmo_q, tmo_d;
  logic [NUM_LANES*SEL_W-1:0]      sel_q, sel_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;
  logic                            busy_q, busy_d;

  logic [NUM_LANES-1:0]            rise_s;
  logic [NUM_LANES-1:0]            new_arr_s;
  logic [SEL_W-1:0]                max_s;

  assign rise_s    = lane_pulse & ~prev_q;
  assign new_arr_s = rise_s & ~flag_q;

  // Largest recorded offset, i.e. the skew of the latest-arriving lane.
  always_comb begin
    max_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (off_q[i] > max_s) begin
        max_s = off_q[i];
      end else begin
        max_s = max_s;
      end
    end
  end

  // Calibration sequencing: next state, capture bookkeeping and output updates.
  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    off_d   = off_q;
    skew_d  = skew_q;
    tmo_d   = tmo_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARMED;
          flag_d  = '0;
          off_d   = '0;
          tmo_d   = '0;
          skew_d  = '0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        // First arrivals define offset 0; offsets are already cleared.
        if (rise_s != '0) begin
          flag_d = rise_s;
          skew_d = SEL_W'(1);
          if (rise_s == {NUM_LANES{1'b1}}) begin
            state_d = ST_COMPUTE;
          end else begin
            state_d = ST_MEASURE;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_MEASURE: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (new_arr_s[i]) begin
            off_d[i] = skew_q;
          end else begin
            off_d[i] = off_q[i];
          end
        end
        flag_d = flag_q | rise_s;
        skew_d = skew_q + SEL_W'(1);
        if (flag_d == {NUM_LANES{1'b1}}) begin
          state_d = ST_COMPUTE;
        end else if (skew_q == SEL_W'(MAX_DLY)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_COMPUTE: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          sel_d[i*SEL_W +: SEL_W] = max_s - off_q[i];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, capture and output registers; rst_n clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      flag_q  <= '0;
      off_q   <= '0;
      skew_q  <= '0;
      tmo_q   <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= lane_pulse;
      flag_q  <= flag_d;
      off_q   <= off_d;
      skew_q  <= skew_d;
      tmo_q   <= tmo_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign sel_out = sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_pulse_skew_calib.sv
// Bench for pulse_skew_calib: per-calibration stimulus plans, an arrival-time
// model that predicts every output cycle, and a per-cycle compare process.
module tb_pulse_skew_calib;

  localparam int NL = 4;
  localparam int MD = 3;
  localparam int TO = 15;
  localparam int N  = 24;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] lane_pulse;
  logic [7:0] sel_out;
  logic       busy;
  logic       done;
  logic       err;

  pulse_skew_calib dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .lane_pulse(lane_pulse),
    .sel_out   (sel_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;
  int base  = -1000;
  bit chk_en = 1'b0;

  logic [3:0] plan_p [N];
  bit         plan_s [N];
  logic [7:0] exp_sel  [N];
  bit         exp_busy [N];
  bit         exp_done [N];
  bit         exp_err  [N];
  logic [7:0] idle_sel = 8'h00;
  bit         idle_err = 1'b0;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Every cycle, outputs must match the plan's prediction (or the idle values).
  always @(negedge clk) begin : cmp_p
    int idx;
    logic [7:0] es;
    bit eb, ed, ee;
    if (chk_en) begin
      idx = ecnt - base;
      if (idx >= 0 && idx < N) begin
        es = exp_sel[idx]; eb = exp_busy[idx]; ed = exp_done[idx]; ee = exp_err[idx];
      end else begin
        es = idle_sel; eb = 1'b0; ed = 1'b0; ee = idle_err;
      end
      tests++;
      if (sel_out !== es || busy !== eb || done !== ed || err !== ee) begin
        fails++;
        $display("FAIL cycle t=%0t idx=%0d: got sel=%h busy=%b done=%b err=%b, want sel=%h busy=%b done=%b err=%b",
                 $time, idx, sel_out, busy, done, err, es, eb, ed, ee);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, expv);
    end
  endtask

  task automatic clear_plan();
    for (int k = 0; k < N; k++) begin
      plan_p[k] = 4'h0;
      plan_s[k] = 1'b0;
    end
    plan_s[0] = 1'b1;
  endtask

  // Predict outputs from arrival times, then drive the plan cycle by cycle.
  task automatic run_plan(input logic [3:0] pre, input bit xs);
    int f, e, l;
    int ki [NL];
    bit ok;
    logic [3:0] rise;
    logic [7:0] nsel;
    f = -1;
    for (int k = 1; k <= TO; k++) begin
      rise = plan_p[k] & ~plan_p[k-1];
      if (f < 0 && rise != 4'h0) f = k;
    end
    ok = 1'b0; e = TO; l = 0; nsel = 8'h00;
    if (f >= 0) begin
      ok = 1'b1;
      for (int i = 0; i < NL; i++) begin
        ki[i] = -1;
        for (int k = f; k <= f + MD; k++) begin
          if (ki[i] < 0 && plan_p[k][i] && !plan_p[k-1][i]) ki[i] = k;
        end
        if (ki[i] < 0) ok = 1'b0;
        else if (ki[i] > l) l = ki[i];
      end
      if (!ok) e = f + MD;
      else for (int i = 0; i < NL; i++) nsel[i*2 +: 2] = 2'(l - ki[i]);
    end
    for (int k = 0; k < N; k++) begin
      exp_sel[k] = idle_sel; exp_done[k] = 1'b0;
      if (ok) begin
        exp_busy[k] = (k <= l);
        exp_err[k]  = 1'b0;
        if (k == l + 1) exp_done[k] = 1'b1;
        if (k >= l + 1) exp_sel[k] = nsel;
      end else begin
        exp_busy[k] = (k < e);
        exp_err[k]  = (k >= e);
      end
    end
    if (xs && f > 0 && exp_busy[f]) plan_s[f+1] = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lane_pulse = pre;
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      if (k == 0) base = ecnt + 1;
      start = plan_s[k]; lane_pulse = plan_p[k];
    end
    @(posedge clk); #1;
    start = 1'b0; lane_pulse = 4'h0;
    if (ok) idle_sel = nsel;
    idle_err = !ok;
    @(posedge clk); #1;
  endtask

  task automatic gen_random(output logic [3:0] pre_o, output bit xs_o);
    int f0, off, kr;
    clear_plan();
    pre_o = 4'($urandom_range(0, 15));
    xs_o  = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) plan_p[0] = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 9) != 0) begin
      f0 = $urandom_range(1, 10);
      for (int i = 0; i < NL; i++) begin
        off = $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) off = $urandom_range(4, 5);
        plan_p[f0+off][i] = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          kr = f0 + off + 2 + $urandom_range(0, 3);
          plan_p[kr][i] = 1'b1;
        end
      end
    end
  endtask

  initial begin : main_p
    logic [3:0] pre;
    bit xs;
    rst_n = 1'b0; start = 1'b0; lane_pulse = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sel", {24'd0, sel_out}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    chk("reset_done", {31'd0, done}, 32'h0);
    chk("reset_err", {31'd0, err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All lanes in the same cycle.
    clear_plan(); plan_p[2] = 4'hF;
    run_plan(4'h0, 1'b0);
    chk("same_cycle_sel", {24'd0, sel_out}, 32'h00);

    // Staircase 0,1,2,3 with a re-pulse on lane0 and an ignored start.
    clear_plan(); plan_p[2] = 4'h1; plan_p[3] = 4'h2; plan_p[4] = 4'h5; plan_p[5] = 4'h8;
    run_plan(4'h0, 1'b1);
    chk("staircase_sel", {24'd0, sel_out}, 32'h1B);

    // Lane2 early, the rest two cycles later.
    clear_plan(); plan_p[2] = 4'h4; plan_p[4] = 4'hB;
    run_plan(4'h0, 1'b0);
    chk("lane2_early_sel", {24'd0, sel_out}, 32'h20);

    // Lane3 at offset 4 is out of range.
    clear_plan(); plan_p[2] = 4'h7; plan_p[6] = 4'h8;
    run_plan(4'h0, 1'b0);
    chk("skew_err_sel", {24'd0, sel_out}, 32'h20);
    chk("skew_err_flag", {31'd0, err}, 32'h1);

    // No pulses at all.
    clear_plan();
    run_plan(4'h0, 1'b0);
    chk("timeout_err", {31'd0, err}, 32'h1);

    // Lane1 held high across start; its real edge comes one cycle late.
    clear_plan(); plan_p[0] = 4'h2; plan_p[1] = 4'h2; plan_p[2] = 4'h2;
    plan_p[3] = 4'hD; plan_p[4] = 4'h2;
    run_plan(4'h2, 1'b0);
    chk("held_level_sel", {24'd0, sel_out}, 32'h51);

    // Reset in the middle of a measurement.
    chk_en = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; lane_pulse = 4'h1;
    @(posedge clk); #1; lane_pulse = 4'h0;
    @(posedge clk); #1;
    chk("pre_reset_busy", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midreset_sel", {24'd0, sel_out}, 32'h0);
    chk("midreset_busy", {31'd0, busy}, 32'h0);
    chk("midreset_err", {31'd0, err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_sel = 8'h00; idle_err = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    clear_plan(); plan_p[3] = 4'h1; plan_p[4] = 4'h2; plan_p[5] = 4'h4; plan_p[6] = 4'h8;
    run_plan(4'h0, 1'b0);
    chk("post_reset_sel", {24'd0, sel_out}, 32'h1B);

    for (int n = 0; n < 60; n++) begin
      gen_random(pre, xs);
      run_plan(pre, xs);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_skew_calib.md
Name: pulse_skew_calib

Overview:
- Deskew calibration engine: measures the per-lane arrival skew of a training pulse across NUM_LANES lanes.
- Produces per-lane delay selects that make all lanes line up at the latest-arriving lane.
- Feeds the sel inputs of the per-lane dynamic pulse-delay stages.
- Sits on the receive side ahead of the lane delay lines; triggered by link training logic via start.

Parameters:
- NUM_LANES, 4, number of lanes measured.
- MAX_DLY, 3, largest delay (cycles) a lane delay stage can apply; the largest skew that can be corrected.
- SEL_W, $clog2(MAX_DLY+1) (2 at default), width of each lane select. Derived; not overridden.
- TIMEOUT, 15, cycles to wait in ARMED for the first pulse before flagging an error.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request to begin a calibration.
- lane_pulse  input  NUM_LANES  training pulse per lane, synchronous to clk.
- sel_out  output  NUM_LANES*SEL_W  per-lane delay select; lane i occupies bits [i*SEL_W +: SEL_W].
- busy  output  1  high while in any state other than IDLE.
- done  output  1  single-cycle pulse when sel_out has been updated.
- err  output  1  sticky calibration-failure flag.

Behaviour:
- Reset values: sel_out=0, busy=0, done=0, err=0. All internal state is cleared, including the per-lane arrival flags, offsets, counters and the rising-edge history register (all zero).
- Arrival detection:
  - Lane arrival = rising edge, i.e. lane_pulse[i]=1 and its registered previous value=0.
  - The history register updates every cycle, in all states.
  - Only the first arrival per lane per calibration is recorded; later edges on a captured lane are ignored.
- States: IDLE, ARMED, MEASURE, COMPUTE.
- IDLE:
  - start=1 -> ARMED.
  - On entry to ARMED: arrival flags, offsets and the timeout counter are cleared, and err is cleared.
  - start is ignored in every state other than IDLE.
- ARMED:
  - Timeout counter increments each cycle.
  - Any arrival(s) -> those lanes record offset 0, the skew counter is set to 1, and the state goes to MEASURE. Exception: if every lane arrives in that same cycle, the state goes directly to COMPUTE.
  - Timeout counter reaches TIMEOUT with no arrival -> err=1, state goes to IDLE.
- MEASURE:
  - Each cycle, lanes arriving record offset = skew counter value; the skew counter then increments.
  - Once all lanes are flagged (including via arrivals in the current cycle) -> COMPUTE.
  - If the skew counter equals MAX_DLY and lanes are still missing after this cycle's arrivals -> err=1, state goes to IDLE. A lane that arrives at offset MAX_DLY+1 or later is therefore an error.
- COMPUTE (one cycle):
  - M = max of the recorded offsets.
  - sel_out[i] = M - offset[i] for each lane i, so the latest lane gets 0.
  - sel_out is registered at the end of COMPUTE; done=1 in the following cycle, coincident with the new sel_out value; state goes to IDLE.
- Latency: the cycle in which the last lane is sampled, then COMPUTE, then the done cycle, so done appears 2 cycles after the last arrival edge.
- sel_out holds its last successful value through a new calibration and through any error. It changes only at done.
- err stays high until the next accepted start.
- done and err are never high in the same cycle.
- Offset arithmetic is unsigned on SEL_W bits. M - offset[i] cannot underflow because M >= offset[i].
- Reset asserted mid-calibration -> immediate return to IDLE with all reset values; a calibration in progress is lost and sel_out returns to 0.
- The block is fully synchronous except the rst_n clear. No combinational path from inputs to outputs.

Test Plan:
- Reset, then start; all 4 lanes rise in the same cycle -> done 2 cycles after the edge, sel_out = {0,0,0,0}, err=0.
- start; lane0, lane1, lane2, lane3 rise at offsets 0,1,2,3 -> sel_out lane0..3 = 3,2,1,0; done one cycle only; busy falls with done.
- start; lane2 at offset 0, lanes 0,1,3 at offset 2 -> sel_out lane0..3 = 0,0,2,0. Then start; lane3 arrives at offset 4 -> err=1, sel_out keeps {0,0,2,0}, no done.
- start with no pulses -> err=1 after 15 cycles in ARMED, busy=0. A second start mid-MEASURE is ignored. A re-pulse on an already-captured lane does not change its offset.
- lane_pulse[1] held high across start (no rising edge), then a clean edge at offset 1 -> the held level is ignored and lane1 offset = 1.
- Assert rst_n low during MEASURE after a prior success -> sel_out=0, busy=0, err=0 immediately. A new calibration then completes normally.
